// File: rtl/lfsr_rng_ranged_pkg.sv
// ----------------------------------------------------------------------------
// rng_pkg : shared types and constants for the ranged LFSR random generator.
//   - rng_state_e : draw FSM states (IDLE / DRAW / HOLD)
//   - DEF_TAPS    : default Fibonacci tap mask (taps 32,22,2,1)
//   - DEF_SEED    : default reset seed
//   - pow2_mask() : smallest 2^k-1 that covers a value (0 maps to 0)
// ----------------------------------------------------------------------------
package rng_pkg;

    localparam int unsigned DEF_LFSR_W = 32;
    localparam logic [63:0] DEF_TAPS   = 64'h0000_0000_8020_0003;
    localparam logic [63:0] DEF_SEED   = 64'h0000_0000_6B1C_CA14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_HOLD = 2'd2
    } rng_state_e;

    // Bit i of the mask is set when v has any set bit at or above position i.
    function automatic logic [63:0] pow2_mask(input logic [63:0] v);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            m[i] = |(v >> i);
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_rng_ranged_lfsr_core.sv
// ----------------------------------------------------------------------------
// lfsr_core : parametrised Fibonacci LFSR with XNOR feedback.
//   CLK       in  clock, rising edge
//   RST       in  asynchronous active-high reset (loads SEED)
//   en_i      in  advance enable
//   seed_ld_i in  synchronous seed load, priority over shifting
//   seed_i    in  seed value; all-ones (XNOR lockup) is replaced by SEED
//   r_o       out current register contents
// ----------------------------------------------------------------------------
module lfsr_core
    import rng_pkg::*;
#(
    parameter int unsigned        LFSR_W = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0]  TAPS   = LFSR_W'(DEF_TAPS),
    parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(DEF_SEED)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en_i,
    input  logic              seed_ld_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [LFSR_W-1:0] r_o
);

    logic [LFSR_W-1:0] r_q, r_d;
    logic              fb;

    assign fb  = ~^(r_q & TAPS);
    assign r_o = r_q;

    // Next state: reload beats shift; an all-ones seed would lock XNOR feedback.
    always_comb begin
        r_d = r_q;
        if (seed_ld_i) begin
            r_d = (&seed_i) ? SEED : seed_i;
        end else if (en_i) begin
            r_d = {r_q[LFSR_W-2:0], fb};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q <= SEED;
        end else begin
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/lfsr_rng_ranged.sv
// ----------------------------------------------------------------------------
// lfsr_rng_ranged : LFSR random generator with a REQ/VALID/ACK handshake that
// returns a value in [0, LIMIT] via bounded rejection sampling.
//   CLK      in  system clock, rising edge
//   RST      in  asynchronous active-high reset
//   EN       in  LFSR advance enable; low freezes the LFSR and stalls draws
//   SEED_LD  in  synchronous seed-load strobe
//   SEED_IN  in  seed value for SEED_LD
//   REQ      in  draw request (IDLE, or HOLD together with ACK)
//   LIMIT    in  inclusive upper bound, captured when REQ is accepted
//   ACK      in  consumer has taken RANDOM (HOLD only)
//   VALID    out RANDOM holds a completed draw
//   RANDOM   out drawn value
//   REJ_CNT  out saturating rejected-candidate count (only with RNG_STATS_EN)
// Build option: define RNG_STATS_EN to add the REJ_CNT port and counter.
// ----------------------------------------------------------------------------
module lfsr_rng_ranged
    import rng_pkg::*;
#(
    parameter int unsigned        LFSR_W    = DEF_LFSR_W,
    parameter int unsigned        OUT_W     = 8,
    parameter logic [LFSR_W-1:0]  TAPS      = LFSR_W'(DEF_TAPS),
    parameter logic [LFSR_W-1:0]  SEED      = LFSR_W'(DEF_SEED),
    parameter int unsigned        MAX_TRIES = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              SEED_LD,
    input  logic [LFSR_W-1:0] SEED_IN,
    input  logic              REQ,
    input  logic [OUT_W-1:0]  LIMIT,
    input  logic              ACK,
    output logic              VALID,
    output logic [OUT_W-1:0]  RANDOM
`ifdef RNG_STATS_EN
    ,
    output logic [15:0]       REJ_CNT
`endif
);

    localparam int unsigned TRY_W = 8;

    rng_state_e         state_q, state_d;
    logic [OUT_W-1:0]   random_q, random_d;
    logic [OUT_W-1:0]   limit_q, limit_d;
    logic               valid_q, valid_d;
    logic [TRY_W-1:0]   tries_q, tries_d;

    logic [LFSR_W-1:0]  lfsr_r;
    logic               step;
    logic [OUT_W-1:0]   mask;
    logic [OUT_W-1:0]   cand;
    logic               cand_ok;
    logic               last_try;
    logic [OUT_W:0]     fold;
    logic               unused_lfsr_hi;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .CLK       (CLK),
        .RST       (RST),
        .en_i      (EN),
        .seed_ld_i (SEED_LD),
        .seed_i    (SEED_IN),
        .r_o       (lfsr_r)
    );

    // Only the low OUT_W bits of the LFSR feed candidates.
    assign unused_lfsr_hi = ^lfsr_r;

    // A DRAW evaluation happens only on edges where the LFSR really shifts.
    assign step     = EN & ~SEED_LD;
    assign mask     = OUT_W'(pow2_mask(64'(limit_q)));
    assign cand     = lfsr_r[OUT_W-1:0] & mask;
    assign cand_ok  = (cand <= limit_q);
    assign last_try = (tries_q == TRY_W'(MAX_TRIES - 1));
    // Fallback fold: cand <= 2*limit+1, so cand-(limit+1) lands in range.
    assign fold     = {1'b0, cand} - ({1'b0, limit_q} + (OUT_W+1)'(1));

    // Next-state and handshake logic.
    always_comb begin
        state_d  = state_q;
        random_d = random_q;
        limit_d  = limit_q;
        valid_d  = valid_q;
        tries_d  = tries_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    limit_d = LIMIT;
                    tries_d = '0;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (step) begin
                    if (cand_ok) begin
                        random_d = cand;
                        valid_d  = 1'b1;
                        state_d  = ST_HOLD;
                    end else if (last_try) begin
                        random_d = OUT_W'(fold);
                        valid_d  = 1'b1;
                        state_d  = ST_HOLD;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (ACK) begin
                    valid_d = 1'b0;
                    if (REQ) begin
                        limit_d = LIMIT;
                        tries_d = '0;
                        state_d = ST_DRAW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            random_q <= '0;
            limit_q  <= '0;
            valid_q  <= 1'b0;
            tries_q  <= '0;
        end else begin
            state_q  <= state_d;
            random_q <= random_d;
            limit_q  <= limit_d;
            valid_q  <= valid_d;
            tries_q  <= tries_d;
        end
    end

    assign VALID  = valid_q;
    assign RANDOM = random_q;

`ifdef RNG_STATS_EN
    logic        rej_inc;
    logic [15:0] rej_q;

    // Every non-accepting evaluation counts, including the fallback one.
    assign rej_inc = (state_q == ST_DRAW) & step & ~cand_ok;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rej_q <= '0;
        end else if (rej_inc && (rej_q != 16'hFFFF)) begin
            rej_q <= rej_q + 16'd1;
        end
    end

    assign REJ_CNT = rej_q;
`endif

endmodule
